// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the register file write port: ALU path A has priority, slow path B is FIFO-buffered
// with a starvation counter. Optional macro REGFILE_WR_ARB_SQUASH_EN kills queued B writes overwritten by A.
module regfile_wr_arbiter #(
  parameter int N          = 64,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_addr,
  input  logic [N-1:0]             a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_addr,
  input  logic [N-1:0]             b_data,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [N-1:0]             wd3,
  output logic [$clog2(DEPTH):0]   b_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);
  localparam logic [4:0]    XZR      = 5'd31;

  logic [4:0]    addr_mem [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [SW-1:0] starve_cnt_reg;

  logic          has_head, force_b, grant_a, grant_b, push;
  logic          head_dead, head_write;
  logic [4:0]    head_addr;
  logic [N-1:0]  head_data;

  assign has_head  = (b_count != '0);
  assign force_b   = has_head && (starve_cnt_reg == STARVE_C);
  assign a_ready   = reset && !force_b;
  // b_ready looks only at current occupancy, so a full FIFO stays closed even on a pop cycle.
  assign b_ready   = reset && (b_count < DEPTH_C);
  assign grant_a   = a_valid && a_ready;
  assign grant_b   = has_head && !grant_a;
  assign push      = b_valid && b_ready;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign busy      = has_head || we3;

`ifdef REGFILE_WR_ARB_SQUASH_EN
  logic [DEPTH-1:0] dead_reg;
  logic [DEPTH-1:0] squash_hit;

  // Slots outside the occupied range may get marked too; harmless, since a push always clears the bit.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
    assign squash_hit[gi] = grant_a && (addr_mem[gi] == a_addr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dead_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_reg == PW'(i)))
          dead_reg[i] <= 1'b0;
        else if (squash_hit[i])
          dead_reg[i] <= 1'b1;
      end
    end
  end

  assign head_dead = dead_reg[rd_ptr_reg];
`else
  assign head_dead = 1'b0;
`endif

  assign head_write = (head_addr != XZR) && !head_dead;

  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_mem[wr_ptr_reg] <= b_addr;
      data_mem[wr_ptr_reg] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we3            <= 1'b0;
      wa3            <= '0;
      wd3            <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      b_count        <= '0;
      starve_cnt_reg <= '0;
    end else begin
      if (grant_a) begin
        we3 <= (a_addr != XZR);
        if (a_addr != XZR) begin
          wa3 <= a_addr;
          wd3 <= a_data;
        end
      end else if (grant_b) begin
        we3 <= head_write;
        if (head_write) begin
          wa3 <= head_addr;
          wd3 <= head_data;
        end
      end else begin
        we3 <= 1'b0;
      end

      if (push)    wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (grant_b) rd_ptr_reg <= rd_ptr_reg + PW'(1);

      case ({push, grant_b})
        2'b10:   b_count <= b_count + CW'(1);
        2'b01:   b_count <= b_count - CW'(1);
        default: b_count <= b_count;
      endcase

      if (has_head && grant_a) begin
        if (starve_cnt_reg != STARVE_C)
          starve_cnt_reg <= starve_cnt_reg + SW'(1);
      end else begin
        starve_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters.
- Port A is the ALU writeback path: high priority, normally never stalled.
- Port B is the slow-unit writeback path (load / multicycle result). It is buffered in a DEPTH-entry FIFO and protected from starvation by a counter.
- Writes to X31 (XZR) are accepted and discarded, so we3 never pulses for address 31.

Parameters:
- N, 64, data width of a_data/b_data/wd3
- DEPTH, 2, port-B FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO head may lose to A before B is forced

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- a_valid  input  1  port A write request
- a_ready  output  1  port A accepted this cycle (combinational)
- a_addr  input  5  port A destination register
- a_data  input  N  port A write data
- b_valid  input  1  port B write request
- b_ready  output  1  port B FIFO has space (combinational)
- b_addr  input  5  port B destination register
- b_data  input  N  port B write data
- we3  output  1  register file write enable (registered)
- wa3  output  5  register file write address (registered)
- wd3  output  N  register file write data (registered)
- b_count  output  $clog2(DEPTH)+1  FIFO occupancy (registered)
- busy  output  1  FIFO non-empty or we3 high

Behaviour:
- Reset (reset==0 at a posedge):
  - we3=0, wa3=0, wd3=0.
  - FIFO emptied, b_count=0, starve_cnt=0.
  - While reset==0: a_ready=0, b_ready=0.
  - Reset mid-operation discards all FIFO entries and any pending write. No we3 pulse occurs after the reset edge.
- Handshake: a transfer occurs on a posedge where valid && ready. Data and addr must be stable while valid && !ready.
- b_ready = (b_count < DEPTH).
  - No pass-through when full: a pop in the same cycle does not raise b_ready.
  - An accepted B enters the FIFO tail at the edge.
- Arbitration is evaluated every cycle over A (a_valid) and the FIFO head (b_count>0). Define force_b = (b_count>0) && (starve_cnt==STARVE_MAX).
  - force_b=1: grant head, a_ready=0.
  - force_b=0: a_ready=1. If a_valid, grant A; otherwise grant head if non-empty.
  - Nothing to grant: we3 goes 0 at the next edge.
- Grant effect at the edge:
  - we3 = (granted addr != 31).
  - wa3/wd3 = granted addr/data. When we3=0, wa3/wd3 hold their previous values.
  - A granted head is popped, including addr-31 entries.
- Latency:
  - A: accept edge → we3 high for exactly 1 cycle after that edge.
  - B: minimum 2 edges (push edge, then grant edge).
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each edge where the head is non-empty and A is granted.
  - Clears when the head is granted or the FIFO is empty.
- Simultaneous B push and head pop: b_count unchanged, FIFO order preserved.
- Ordering: A-vs-A and B-vs-B writes retire in acceptance order. A-vs-B order is grant order (see Optional Feature).
- Pointers wrap modulo DEPTH. b_count ranges 0..DEPTH.

Optional Feature:
- Macro: REGFILE_WR_ARB_SQUASH_EN
- Defined:
  - When A is granted, every valid FIFO entry whose addr equals a_addr is marked dead; the newer A value wins.
  - A dead entry still pops and counts toward b_count when granted, but produces we3=0.
  - A port-B entry accepted in the same cycle is not squashed.
- Undefined: no comparison; both writes retire in grant order, so the last writer is whichever is granted later.

Test Plan:
- Reset:
  - Stimulus: drive reset=0 for 2 cycles with a_valid=b_valid=1.
  - Response: a_ready=b_ready=0, we3=0, b_count=0 throughout. After reset=1, the first A write (addr 5, data 0x55) gives we3=1, wa3=5, wd3=0x55 one cycle after acceptance.
- XZR discard:
  - Stimulus: A write addr 31 data 0xFF, then B write addr 31.
  - Response: both handshakes complete, we3 stays 0, b_count returns to 0.
- FIFO full:
  - Stimulus: hold a_valid=1 continuously; push B addr 1, 2, 3 back-to-back with DEPTH=2.
  - Response: b_ready=0 after 2 pushes, b_count=2. B addr 3 is held until a slot frees.
- Starvation:
  - Stimulus: a_valid=1 continuously with B addr 7 data 0x77 queued.
  - Response: a_ready drops to 0 in exactly one cycle after STARVE_MAX=4 A grants. Next cycle we3=1, wa3=7, wd3=0x77; a_ready returns to 1.
- Reset mid-operation:
  - Stimulus: b_count=2 and A just accepted, then reset=0 for 1 cycle.
  - Response: no we3 pulse after the reset edge, b_count=0. The dropped entries never appear.
- Squash (REGFILE_WR_ARB_SQUASH_EN):
  - Stimulus: B addr 9 data 0x1 queued while A is forced to win; A addr 9 data 0x2.
  - Response with macro: only the 0x2 write occurs to X9.
  - Response without macro: 0x2 then 0x1 occurs to X9.
